// File: rtl/csr_bram_loader.sv
// Byte-stream loader that assembles little-endian 32-bit words of a CSR NFA image
// and writes them to a BRAM write port. Optional trailing checksum: CSR_LOADER_CHECKSUM_EN.
module csr_bram_loader #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 9514
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        error_code,
    output logic [ADDR_W-1:0] words_written
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
`ifdef CSR_LOADER_CHECKSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         acc_q, acc_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   ww_q, ww_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [1:0]          ecode_q, ecode_d;
`ifdef CSR_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                cchk_q, cchk_d;
    logic                cmatch_q, cmatch_d;
`endif

    logic                ready_c;
    logic                accept;
    logic                word_last;
    logic [DATA_W-1:0]   word;

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        acc_d     = acc_q;
        len_d     = len_q;
        ww_d      = ww_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ecode_d   = ecode_q;
`ifdef CSR_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        cchk_d    = cchk_q;
        cmatch_d  = cmatch_q;
`endif

        // Input is closed during the write cycle of the final word so DONE follows it.
        ready_c = 1'b0;
        case (state_q)
            ST_HDR:  ready_c = 1'b1;
            ST_DATA: ready_c = (ww_q != len_q);
`ifdef CSR_LOADER_CHECKSUM_EN
            ST_CSUM: ready_c = !cchk_q;
`endif
            default: ready_c = 1'b0;
        endcase

        accept    = in_valid && ready_c;
        word_last = (bcnt_q == 2'd3);
        word      = {in_byte, acc_q};

        if (accept) begin
            bcnt_d = bcnt_q + 2'd1;
            case (bcnt_q)
                2'd0:    acc_d[7:0]   = in_byte;
                2'd1:    acc_d[15:8]  = in_byte;
                2'd2:    acc_d[23:16] = in_byte;
                default: acc_d        = acc_q;
            endcase
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR;
                    ww_d    = '0;
                    ecode_d = '0;
                    bcnt_d  = '0;
                    acc_d   = '0;
`ifdef CSR_LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    cchk_d  = 1'b0;
`endif
                end
            end
            ST_HDR: begin
                if (accept && word_last) begin
                    if (word > 32'(DEPTH)) begin
                        state_d = ST_ERR;
                        ecode_d = 2'b01;
                    end else if (word == '0) begin
`ifdef CSR_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_DATA;
                        len_d   = word[ADDR_W-1:0];
                    end
                end
            end
            ST_DATA: begin
                if (ww_q == len_q) begin
`ifdef CSR_LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end else if (accept && word_last) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ww_q;
                    wr_data_d = word;
                    ww_d      = ww_q + 1'b1;
`ifdef CSR_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + word;
`endif
                end
            end
`ifdef CSR_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                // Compare is registered so done/error appear two cycles after the last byte.
                if (cchk_q) begin
                    cchk_d = 1'b0;
                    if (cmatch_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                        ecode_d = 2'b10;
                    end
                end else if (accept && word_last) begin
                    cchk_d   = 1'b1;
                    cmatch_d = (word == sum_q);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bcnt_q    <= '0;
            acc_q     <= '0;
            len_q     <= '0;
            ww_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ecode_q   <= '0;
`ifdef CSR_LOADER_CHECKSUM_EN
            sum_q     <= '0;
            cchk_q    <= 1'b0;
            cmatch_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            acc_q     <= acc_d;
            len_q     <= len_d;
            ww_q      <= ww_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ecode_q   <= ecode_d;
`ifdef CSR_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
            cchk_q    <= cchk_d;
            cmatch_q  <= cmatch_d;
`endif
        end
    end

    assign in_ready      = ready_c;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign busy          = (state_q == ST_HDR) || (state_q == ST_DATA)
`ifdef CSR_LOADER_CHECKSUM_EN
                           || (state_q == ST_CSUM)
`endif
                           ;
    assign done          = (state_q == ST_DONE);
    assign error         = (state_q == ST_ERR);
    assign error_code    = ecode_q;
    assign words_written = ww_q;

endmodule
